// File: rtl/audio_pkg.sv
// Shared audio definitions: sample/address widths used by recorder, player and DSP,
// and the recorder state encoding.
package audio_pkg;

    localparam int SAMPLE_W    = 16;
    localparam int SRAM_ADDR_W = 20;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        SHIFT,
        STORE,
        PAUSE
    } rec_state_e;

    // Capture is in progress (or about to be) in these states; PAUSE/IDLE are not.
    function automatic logic is_recording(input rec_state_e state);
        return (state == WAIT) || (state == SHIFT) || (state == STORE);
    endfunction

endpackage

// File: rtl/i2s_deserializer.sv
// Left-channel I2S front end: detects the LRC falling edge, skips the one-bit delay
// slot, and shifts in DATA_W bits MSB first.
module i2s_deserializer
    import audio_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lrc,
    input  logic              data,
    output logic              left_start,
    output logic [DATA_W-1:0] sample,
    output logic              sample_done
);

    localparam int CNT_W = $clog2(DATA_W);

    logic              lrc_q;
    logic              active;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-2:0] shreg;

    // The edge is seen in the delay slot itself; the MSB follows one BCLK later.
    assign left_start  = lrc_q & ~lrc;
    assign sample_done = active && (bit_cnt == CNT_W'(DATA_W - 1));
    // The last bit is taken straight from the pin so the word is ready on the 16th edge.
    assign sample      = {shreg, data};

    // NOTE: all state updates use <= so every register samples pre-edge values;
    // blocking here would let lrc_q and the shifter see this cycle's updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lrc_q   <= 1'b1;
            active  <= 1'b0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            lrc_q <= lrc;
            if (left_start) begin
                active  <= 1'b1;
                bit_cnt <= '0;
            end else if (active) begin
                shreg   <= {shreg[DATA_W-3:0], data};
                bit_cnt <= bit_cnt + 1'b1;
                if (sample_done) begin
                    active <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/i2s_recorder.sv
// Recorder control: turns deserialized left samples into one SRAM write per sample,
// driven by record/pause/stop pulses, and tracks address, count and full status.
module i2s_recorder
    import audio_pkg::*;
#(
    parameter int          DATA_W   = SAMPLE_W,
    parameter int          ADDR_W   = SRAM_ADDR_W,
    parameter int unsigned MAX_ADDR = (2 ** ADDR_W) - 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_lrc,
    input  logic              i_data,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic [ADDR_W:0]   o_count,
    output logic              o_recording,
    output logic              o_full
);

    rec_state_e        state;
    rec_state_e        next_state;
    logic              left_start;
    logic              sample_done;
    logic [DATA_W-1:0] sample;
    logic              at_max;
    logic              clear_rec;
    logic              load_sample;
    logic              commit;

    i2s_deserializer #(
        .DATA_W(DATA_W)
    ) u_deser (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .lrc        (i_lrc),
        .data       (i_data),
        .left_start (left_start),
        .sample     (sample),
        .sample_done(sample_done)
    );

    assign at_max = (o_address == ADDR_W'(MAX_ADDR));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block is defaulted first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state  = state;
        clear_rec   = 1'b0;
        load_sample = 1'b0;
        commit      = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_start) begin
                    next_state = WAIT;
                    clear_rec  = 1'b1;
                end
            end
            WAIT: begin
                if (i_stop) begin
                    next_state = IDLE;
                end else if (i_pause) begin
                    next_state = PAUSE;
                end else if (left_start) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (i_stop) begin
                    next_state = IDLE;
                end else if (i_pause) begin
                    next_state = PAUSE;
                end else if (sample_done) begin
                    next_state  = STORE;
                    load_sample = 1'b1;
                end
            end
            STORE: begin
                // The write on the bus always completes; commands only pick where we go next.
                commit = 1'b1;
                if (at_max || i_stop) begin
                    next_state = IDLE;
                end else if (i_pause) begin
                    next_state = PAUSE;
                end else begin
                    next_state = WAIT;
                end
            end
            PAUSE: begin
                if (i_stop) begin
                    next_state = IDLE;
                end else if (i_pause || i_start) begin
                    next_state = WAIT;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_address <= '0;
            o_count   <= '0;
            o_full    <= 1'b0;
            o_data    <= '0;
        end else begin
            if (clear_rec) begin
                o_address <= '0;
                o_count   <= '0;
                o_full    <= 1'b0;
            end else if (commit) begin
                o_count <= o_count + 1'b1;
                // Address saturates at the top of memory so the player sees the true end.
                if (at_max) begin
                    o_full <= 1'b1;
                end else begin
                    o_address <= o_address + 1'b1;
                end
            end
            if (load_sample) begin
                o_data <= sample;
            end
        end
    end

    assign o_valid     = (state == STORE);
    assign o_recording = is_recording(state);

endmodule

// File: tb/tb_i2s_recorder.sv
// Bench for i2s_recorder: two instances (full-size and MAX_ADDR=3) share one I2S
// stream; a frame-level model predicts writes, address, count and status per frame.
module tb_i2s_recorder;

    localparam int AW    = 20;
    localparam int DW    = 16;
    localparam int MAX0  = (2 ** AW) - 1;
    localparam int MAX1  = 3;
    localparam int FRAME = 64;

    localparam logic [2:0] C_NONE  = 3'b000;
    localparam logic [2:0] C_START = 3'b001;
    localparam logic [2:0] C_PAUSE = 3'b010;
    localparam logic [2:0] C_STOP  = 3'b100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic lrc   = 1'b1;
    logic data  = 1'b0;
    logic start = 1'b0;
    logic pause = 1'b0;
    logic stop  = 1'b0;

    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic          v0, v1, r0, r1, fu0, fu1;
    logic [AW:0]   c0, c1;

    always #5 clk = ~clk;

    i2s_recorder dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_lrc(lrc), .i_data(data),
        .i_start(start), .i_pause(pause), .i_stop(stop),
        .o_address(a0), .o_data(d0), .o_valid(v0), .o_count(c0),
        .o_recording(r0), .o_full(fu0)
    );

    i2s_recorder #(.MAX_ADDR(MAX1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_lrc(lrc), .i_data(data),
        .i_start(start), .i_pause(pause), .i_stop(stop),
        .o_address(a1), .o_data(d1), .o_valid(v1), .o_count(c1),
        .o_recording(r1), .o_full(fu1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    typedef enum {M_IDLE, M_REC, M_PAUSED} mmode_e;
    mmode_e        m_mode[2];
    int            m_addr[2];
    int            m_count[2];
    bit            m_full[2];
    logic [DW-1:0] m_data[2];
    int            m_max[2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d]  = M_IDLE;
            m_addr[d]  = 0;
            m_count[d] = 0;
            m_full[d]  = 1'b0;
            m_data[d]  = '0;
        end
    endtask

    task automatic model_new_rec(input int d);
        m_mode[d]  = M_REC;
        m_addr[d]  = 0;
        m_count[d] = 0;
        m_full[d]  = 1'b0;
    endtask

    // One frame: left start at position 0, sample bits at 1..16, write visible at 17.
    // A command at position p is sampled on the edge ending position p.
    task automatic model_step(input int d, input logic [DW-1:0] s, input logic [2:0] cmd_in,
                              input int at, output bit wr, output int wa);
        logic [2:0] cmd;
        cmd = (at < 0) ? C_NONE : cmd_in;
        wr  = 1'b0;
        wa  = 0;
        case (m_mode[d])
            M_REC: begin
                if ((cmd[2] || cmd[1]) && at <= 16) begin
                    m_mode[d] = cmd[2] ? M_IDLE : M_PAUSED;
                end else begin
                    wr = 1'b1;
                    wa = m_addr[d];
                    m_data[d]  = s;
                    m_count[d] = m_count[d] + 1;
                    if (m_addr[d] == m_max[d]) begin
                        m_full[d] = 1'b1;
                        m_mode[d] = M_IDLE;
                    end else begin
                        m_addr[d] = m_addr[d] + 1;
                    end
                    if (at >= 17) begin
                        if (m_mode[d] == M_REC) begin
                            if (cmd[2]) m_mode[d] = M_IDLE;
                            else if (cmd[1]) m_mode[d] = M_PAUSED;
                        end else if (at >= 18 && cmd[0]) begin
                            model_new_rec(d);
                        end
                    end
                end
            end
            M_PAUSED: begin
                if (cmd[2]) m_mode[d] = M_IDLE;
                else if (cmd[1] || cmd[0]) m_mode[d] = M_REC;
            end
            default: begin
                if (cmd[0]) model_new_rec(d);
            end
        endcase
    endtask

    // ---------------- stimulus and per-frame observation ----------------
    int            f_nv[2], f_vj[2];
    logic [AW-1:0] f_va[2];
    logic [DW-1:0] f_vd[2];
    logic [AW-1:0] e_addr[2];
    logic [AW:0]   e_cnt[2];
    logic          e_full[2], e_rec[2];
    logic [DW-1:0] e_data[2];
    int            frame_no = 0;

    task automatic check_all_zero(input string tag);
        check({tag, " d0 addr"},  a0,  0);
        check({tag, " d0 data"},  d0,  0);
        check({tag, " d0 valid"}, v0,  0);
        check({tag, " d0 count"}, c0,  0);
        check({tag, " d0 rec"},   r0,  0);
        check({tag, " d0 full"},  fu0, 0);
        check({tag, " d1 addr"},  a1,  0);
        check({tag, " d1 valid"}, v1,  0);
        check({tag, " d1 count"}, c1,  0);
        check({tag, " d1 full"},  fu1, 0);
    endtask

    task automatic run_frame(input logic [DW-1:0] s, input logic [2:0] cmd, input int at,
                             input int rst_at);
        bit    wr;
        int    wa;
        string tag;
        tag = $sformatf("frame%0d", frame_no);
        f_nv = '{0, 0};
        f_vj = '{-1, -1};
        for (int j = 0; j < FRAME; j++) begin
            @(negedge clk);
            if (v0) begin f_nv[0]++; f_vj[0] = j; f_va[0] = a0; f_vd[0] = d0; end
            if (v1) begin f_nv[1]++; f_vj[1] = j; f_va[1] = a1; f_vd[1] = d1; end
            if (j == FRAME - 1) begin
                e_addr = '{a0, a1};
                e_cnt  = '{c0, c1};
                e_full = '{fu0, fu1};
                e_rec  = '{r0, r1};
                e_data = '{d0, d1};
            end
            lrc  = (j >= FRAME / 2);
            data = (j >= 1 && j <= 16) ? s[16-j] : 1'($urandom);
            {stop, pause, start} = (j == at) ? cmd : C_NONE;
            if (j == rst_at) begin
                #2 rst_n = 1'b0;
                #1 check_all_zero({tag, " async reset"});
                model_reset();
            end
            if (rst_at >= 0 && j == rst_at + 3) rst_n = 1'b1;
        end
        for (int d = 0; d < 2; d++) begin
            model_step(d, s, cmd, at, wr, wa);
            check($sformatf("%s d%0d write count", tag, d), f_nv[d], wr ? 1 : 0);
            if (wr) begin
                check($sformatf("%s d%0d write slot", tag, d), f_vj[d], 17);
                check($sformatf("%s d%0d write addr", tag, d), f_va[d], wa);
                check($sformatf("%s d%0d write data", tag, d), f_vd[d], s);
            end
            check($sformatf("%s d%0d end addr", tag, d),  e_addr[d], m_addr[d]);
            check($sformatf("%s d%0d end count", tag, d), e_cnt[d],  m_count[d]);
            check($sformatf("%s d%0d end full", tag, d),  e_full[d], m_full[d]);
            check($sformatf("%s d%0d end rec", tag, d),   e_rec[d],  m_mode[d] == M_REC);
            check($sformatf("%s d%0d end data", tag, d),  e_data[d], m_data[d]);
        end
        frame_no++;
    endtask

    // ---------------- directed table (expectations for the full-size instance) ----------------
    typedef struct {
        logic [DW-1:0] sample;
        logic [2:0]    cmd;
        int            at;
        bit            exp_wr;
        int            exp_wa;
        int            exp_end_addr;
        int            exp_count;
        bit            exp_rec;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs[20];

    initial begin
        int wsum;
        vecs[0]  = '{16'hFFFF, C_START, 40, 0, 0, 0, 0, 1, 16'h0000};
        vecs[1]  = '{16'hA5C3, C_NONE,  -1, 1, 0, 1, 1, 1, 16'hA5C3};
        vecs[2]  = '{16'h0001, C_NONE,  -1, 1, 1, 2, 2, 1, 16'h0001};
        vecs[3]  = '{16'h8000, C_NONE,  -1, 1, 2, 3, 3, 1, 16'h8000};
        vecs[4]  = '{16'h1234, C_PAUSE,  6, 0, 0, 3, 3, 0, 16'h8000};
        vecs[5]  = '{16'h0F0F, C_PAUSE, 40, 0, 0, 3, 3, 1, 16'h8000};
        vecs[6]  = '{16'h5678, C_NONE,  -1, 1, 3, 4, 4, 1, 16'h5678};
        vecs[7]  = '{16'h1111, C_STOP,  40, 1, 4, 5, 5, 0, 16'h1111};
        vecs[8]  = '{16'h2222, C_START, 40, 0, 0, 0, 0, 1, 16'h1111};
        vecs[9]  = '{16'hBEEF, C_NONE,  -1, 1, 0, 1, 1, 1, 16'hBEEF};
        vecs[10] = '{16'h3C3C, C_NONE,  -1, 1, 1, 2, 2, 1, 16'h3C3C};
        vecs[11] = '{16'h7777, C_STOP,  10, 0, 0, 2, 2, 0, 16'h3C3C};
        vecs[12] = '{16'h9999, C_NONE,  -1, 0, 0, 2, 2, 0, 16'h3C3C};
        vecs[13] = '{16'hAAAA, C_START, 40, 0, 0, 0, 0, 1, 16'h3C3C};
        vecs[14] = '{16'h5555, C_STOP | C_PAUSE, 0, 0, 0, 0, 0, 0, 16'h3C3C};
        vecs[15] = '{16'h6666, C_START, 40, 0, 0, 0, 0, 1, 16'h3C3C};
        vecs[16] = '{16'hCAFE, C_STOP,  17, 1, 0, 1, 1, 0, 16'hCAFE};
        vecs[17] = '{16'h4444, C_START, 40, 0, 0, 0, 0, 1, 16'hCAFE};
        vecs[18] = '{16'h1357, C_START,  8, 1, 0, 1, 1, 1, 16'h1357};
        vecs[19] = '{16'h8001, C_NONE,  -1, 1, 1, 2, 2, 1, 16'h8001};

        m_max[0] = MAX0;
        m_max[1] = MAX1;
        model_reset();

        // Reset state
        #3 check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed frames: capture, pause/resume, stop/restart, priority, stop-at-STORE
        foreach (vecs[i]) begin
            run_frame(vecs[i].sample, vecs[i].cmd, vecs[i].at, -1);
            check($sformatf("vec%0d wrote", i), f_nv[0], vecs[i].exp_wr ? 1 : 0);
            if (vecs[i].exp_wr) check($sformatf("vec%0d addr", i), f_va[0], vecs[i].exp_wa);
            check($sformatf("vec%0d end addr", i),  e_addr[0], vecs[i].exp_end_addr);
            check($sformatf("vec%0d count", i),     e_cnt[0],  vecs[i].exp_count);
            check($sformatf("vec%0d rec", i),       e_rec[0],  vecs[i].exp_rec);
            check($sformatf("vec%0d data", i),      e_data[0], vecs[i].exp_data);
        end

        // Fill the small memory: 5 frames give exactly 4 writes, then sticky full
        run_frame(16'h0, C_STOP, 40, -1);
        run_frame(16'h0, C_START, 40, -1);
        wsum = 0;
        for (int k = 0; k < 5; k++) begin
            run_frame(16'($urandom), C_NONE, -1, -1);
            wsum += f_nv[1];
        end
        check("full writes", wsum, 4);
        check("full flag", e_full[1], 1);
        check("full count", e_cnt[1], 4);
        check("full addr held", e_addr[1], MAX1);
        check("full idle", e_rec[1], 0);
        run_frame(16'h0, C_START, 40, -1);
        check("full cleared", e_full[1], 0);
        check("restart count", e_cnt[1], 0);

        // Async reset in the middle of a sample, then frames with no start
        run_frame(16'hDEAD, C_NONE, -1, 8);
        wsum = 0;
        for (int k = 0; k < 2; k++) begin
            run_frame(16'($urandom), C_NONE, -1, -1);
            wsum += f_nv[0] + f_nv[1];
        end
        check("no write after reset", wsum, 0);

        // Random frames with single random command pulses
        for (int k = 0; k < 80; k++) begin
            int r;
            int at;
            logic [2:0] cmd;
            r   = $urandom_range(0, 9);
            cmd = (r < 2) ? C_START : (r < 4) ? C_PAUSE : (r < 5) ? C_STOP : C_NONE;
            at  = $urandom_range(0, 61);
            if (at >= 17) at++;
            run_frame(16'($urandom), cmd, at, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
